div_iter32: RTL and testbench

- Multi-cycle iterative integer divider for the single-cycle datapath.
- Produces quotient/remainder for DIV/DIVU (LO/HI), which feed the 32-bit writeback-select 2:1 mux as its alternate input.
- Retires one quotient bit per cycle (restoring algorithm).
- Start/busy/done handshake; the control unit stalls PC while busy.

---
 rtl/div_iter32.sv | 94 +++++++++
 tb/tb_div_iter32.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/div_iter32.sv
// div_iter32: restoring iterative divider, one quotient bit per cycle, start/busy/done handshake.
// Define DIV_SIGNED_EN to honour the sign input (DIV); otherwise every operation is unsigned (DIVU).
module div_iter32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dmag, raw, a_mag, b_mag, q_fin, r_fin;
  logic [WIDTH:0] shifted, diff;
  logic div0, accept, ge;
  // the cycle done is high is still the DONE cycle, so start is refused there
  assign accept = state == IDLE && start && !done;
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff = shifted - {1'b0, dmag};
  assign ge = shifted >= {1'b0, dmag};
`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;
  assign a_mag = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_mag = (sign && divisor[WIDTH-1]) ? -divisor : divisor;
  assign q_fin = neg_q ? -quo : quo;
  assign r_fin = neg_r ? -rem : rem;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r <= sign & dividend[WIDTH-1];
    end
`else
  logic unused_sign;
  assign unused_sign = sign;
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fin = quo;
  assign r_fin = rem;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dmag      <= '0;
      raw       <= '0;
      div0      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy <= accept;
          done <= 1'b0;
          if (accept) begin
            quo   <= a_mag;
            dmag  <= b_mag;
            raw   <= dividend;
            div0  <= divisor == '0;
            rem   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          rem <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          quotient  <= div0 ? '1 : q_fin;
          remainder <= div0 ? raw : r_fin;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_div_iter32.sv
// tb_div_iter32: directed vectors for div_iter32 with an arithmetic reference model checked every cycle.
module tb_div_iter32;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n, start, sign, busy, done;
  logic [31:0] dividend, divisor, quotient, remainder;
  int ncmp = 0, nfail = 0;

  div_iter32 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign(sign),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (SIGNED_EN && s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // reference timeline: accepted at age 0, done cycle after age 33, idle again after age 34
  bit act = 0;
  int age = 0;
  logic [31:0] nq = 0, nr = 0, eq = 0, er = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      act = 0;
      eq = 0;
      er = 0;
    end else if (act) begin
      age++;
      if (age == 34) act = 0;
    end else if (start) begin
      act = 1;
      age = 0;
      model(sign, dividend, divisor, nq, nr);
    end
    if (act && age == 33) begin
      eq = nq;
      er = nr;
    end
    #1;
    chk("cyc_busy", {31'b0, busy}, {31'b0, act});
    chk("cyc_done", {31'b0, done}, {31'b0, act && age == 33});
    chk("cyc_quotient", quotient, eq);
    chk("cyc_remainder", remainder, er);
  end

  task automatic go(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    sign = s;
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #3 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [31:0] q, input logic [31:0] r);
    int n;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({name, "_latency"}, 32'(n), 32'd34);
    chk({name, "_q"}, quotient, q);
    chk({name, "_r"}, remainder, r);
  endtask

  initial begin
    logic [31:0] q, r;
    rst_n = 1'b0;
    start = 1'b0;
    sign = 1'b0;
    dividend = '0;
    divisor = '0;
    model(0, 100, 7, q, r);
    chk("model_udiv_q", q, 14);
    chk("model_udiv_r", r, 2);
    model(1, 32'hFFFF_FFF9, 2, q, r);
    chk("model_sdiv_q", q, SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC);
    chk("model_sdiv_r", r, SIGNED_EN ? 32'hFFFF_FFFF : 32'h1);
    model(1, 32'h8000_0000, 32'hFFFF_FFFF, q, r);
    chk("model_ovf_q", q, SIGNED_EN ? 32'h8000_0000 : 32'h0);
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_done", {31'b0, done}, 0);
    chk("reset_q", quotient, 0);
    chk("reset_r", remainder, 0);
    rst_n = 1'b1;

    go(0, 100, 7);
    wait_done("udiv", 14, 2);
    go(1, 32'hFFFF_FFF9, 2);
    wait_done("sdiv", SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, SIGNED_EN ? 32'hFFFF_FFFF : 32'h1);
    go(0, 32'h1234_5678, 0);
    wait_done("div0_u", 32'hFFFF_FFFF, 32'h1234_5678);
    go(1, 32'h1234_5678, 0);
    wait_done("div0_s", 32'hFFFF_FFFF, 32'h1234_5678);
    go(1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("ovf", SIGNED_EN ? 32'h8000_0000 : 32'h0, SIGNED_EN ? 32'h0 : 32'h8000_0000);
    go(1, 7, 32'hFFFF_FFFE);
    wait_done("sdiv_negdiv", SIGNED_EN ? 32'hFFFF_FFFD : 32'h0, SIGNED_EN ? 32'h1 : 32'h7);
    go(0, 32'hFFFF_FFFF, 1);
    wait_done("umax", 32'hFFFF_FFFF, 0);

    // start while busy and through the done cycle must not disturb the first result
    go(0, 100, 7);
    repeat (5) @(negedge clk);
    dividend = 55;
    divisor = 3;
    start = 1'b1;
    @(posedge clk);
    #3 start = 1'b0;
    repeat (28) @(negedge clk);
    dividend = 1000;
    divisor = 10;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_done", {31'b0, done}, 1);
    chk("hs_q", quotient, 14);
    chk("hs_r", remainder, 2);
    @(posedge clk);
    #1 chk("hs_idle_busy", {31'b0, busy}, 0);
    @(posedge clk);
    #3 start = 1'b0;
    wait_done("hs_second", 100, 0);

    // asynchronous reset in the middle of a division
    go(0, 100, 7);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) seen = 1;
      end
      chk("rst_no_done", {31'b0, seen}, 0);
    end
    go(0, 1000, 33);
    wait_done("post_rst", 30, 10);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
